// File: rtl/md_pkg.sv
// Shared MD-accelerator types: force writeback records from the force pipelines
// and the packet format carried by the on-chip router.
package md_pkg;

    localparam int NODE_ID_WIDTH = 6;
    localparam int PID_WIDTH     = 7;
    localparam int COORD_WIDTH   = 3;
    localparam int FORCE_WIDTH   = 96;

    typedef struct packed {
        logic [COORD_WIDTH-1:0] cell_id_z;
        logic [COORD_WIDTH-1:0] cell_id_y;
        logic [COORD_WIDTH-1:0] cell_id_x;
        logic [PID_WIDTH-1:0]   particle_id;
    } full_id_t;

    // 120 bits: tag(8) + full id(16) + force tuple(96)
    typedef struct packed {
        logic [7:0]             tag;
        full_id_t               id;
        logic [FORCE_WIDTH-1:0] force_val;
    } force_wb_t;

    typedef struct packed {
        logic [PID_WIDTH-1:0]   particle_id;
        logic [FORCE_WIDTH-1:0] force_val;
    } payload_t;

    // 109 bits: dest_id(6) + payload(103)
    typedef struct packed {
        logic [NODE_ID_WIDTH-1:0] dest_id;
        payload_t                 payload;
    } packet_t;

endpackage

// File: rtl/force_wb_arbiter_if.sv
// Requester-side and router-side handshake bundle of the force writeback arbiter.
interface force_wb_arbiter_if #(
    parameter int NUM_REQ = 4
);
    import md_pkg::*;

    logic [NUM_REQ-1:0] req_valid;
    logic [NUM_REQ-1:0] req_ready;
    force_wb_t          req_data [NUM_REQ];
    logic               out_valid;
    logic               out_ready;
    packet_t            out_pkt;

    // master: the arbiter itself; slave: requesters plus router as seen by a bench
    modport master (
        input  req_valid, req_data, out_ready,
        output req_ready, out_valid, out_pkt
    );

    modport slave (
        output req_valid, req_data, out_ready,
        input  req_ready, out_valid, out_pkt
    );
endinterface

// File: rtl/force_wb_arbiter.sv
// Round-robin arbiter folding NUM_REQ force writeback streams into one router
// injection port through a one-entry, full-throughput output register.
module force_wb_arbiter
    import md_pkg::*;
#(
    parameter int NUM_REQ   = 4,
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    force_wb_arbiter_if.master   bus,
    output logic [CNT_WIDTH-1:0] sent_count,
    output logic                 busy
);

    localparam int               PTR_W     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [PTR_W:0]   NUM_REQ_W = (PTR_W+1)'(NUM_REQ);
    localparam logic [PTR_W-1:0] LAST_IDX  = PTR_W'(NUM_REQ - 1);

    logic [PTR_W-1:0]     r_ptr;
    logic                 r_out_valid;
    packet_t              r_out_pkt;
    logic [CNT_WIDTH-1:0] r_sent_count;

    logic                 w_load_en;
    logic                 w_found;
    logic [PTR_W-1:0]     w_win;
    logic [PTR_W:0]       w_sum;
    logic                 w_handshake;
    logic [NUM_REQ-1:0]   w_ready;
    logic [PTR_W-1:0]     w_ptr_next;
    force_wb_t            w_sel_rec;
    packet_t              w_pkt;
    logic                 w_unused;

    // The register may drain and reload in the same cycle.
    assign w_load_en = !r_out_valid || bus.out_ready;

    // NOTE: every signal driven here gets a default first so no latch is inferred.
    always_comb begin
        w_found = 1'b0;
        w_win   = '0;
        w_sum   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            w_sum = {1'b0, r_ptr} + (PTR_W+1)'(i);
            if (w_sum >= NUM_REQ_W) begin
                w_sum = w_sum - NUM_REQ_W;
            end
            if (!w_found && bus.req_valid[w_sum[PTR_W-1:0]]) begin
                w_found = 1'b1;
                w_win   = w_sum[PTR_W-1:0];
            end
        end
    end

    assign w_handshake = w_found && w_load_en && !rst;

    always_comb begin
        w_ready = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            w_ready[i] = w_handshake && (w_win == PTR_W'(i));
        end
    end

    assign w_ptr_next = (w_win == LAST_IDX) ? '0 : w_win + PTR_W'(1);

    // Bit 2 of each cell coordinate does not take part in routing.
    assign w_sel_rec                   = bus.req_data[w_win];
    assign w_pkt.dest_id               = {w_sel_rec.id.cell_id_z[1:0],
                                          w_sel_rec.id.cell_id_y[1:0],
                                          w_sel_rec.id.cell_id_x[1:0]};
    assign w_pkt.payload.particle_id   = w_sel_rec.id.particle_id;
    assign w_pkt.payload.force_val     = w_sel_rec.force_val;
    assign w_unused = &{1'b0, w_sel_rec.tag, w_sel_rec.id.cell_id_z[2],
                        w_sel_rec.id.cell_id_y[2], w_sel_rec.id.cell_id_x[2]};

    // NOTE: sequential state uses non-blocking assignments so all registers
    // update together from pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr        <= '0;
            r_out_valid  <= 1'b0;
            r_out_pkt    <= '0;
            r_sent_count <= '0;
        end else begin
            if (w_handshake) begin
                r_out_valid <= 1'b1;
                r_out_pkt   <= w_pkt;
                r_ptr       <= w_ptr_next;
            end else if (bus.out_ready) begin
                r_out_valid <= 1'b0;
            end
            if (r_out_valid && bus.out_ready && (r_sent_count != '1)) begin
                r_sent_count <= r_sent_count + CNT_WIDTH'(1);
            end
        end
    end

    assign bus.req_ready = w_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.out_pkt   = r_out_pkt;
    assign sent_count    = r_sent_count;
    assign busy          = r_out_valid || (|bus.req_valid);

endmodule
